// File: rtl/fifo_pkg.sv
// Shared defaults, width helper and status bundle for sync_fifo_param.
package fifo_pkg;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_DEPTH  = 8;

   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almostfull;
      logic almostempty;
   } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array with one write port and one registered read port.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned  DATA_W = DEF_DATA_W,
   parameter int unsigned  DEPTH  = DEF_DEPTH,
   localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [PTR_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [PTR_W-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wr_addr] = wr_data;
      rd_data_d = rd_data_q;
      if (rd_en) rd_data_d = mem_q[rd_addr];
   end

   // Array contents survive reset; only the output register is cleared.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) rd_data_q <= '0;
      else     rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with flags, ack/error pulses and synchronous flush.
// Define FIFO_COUNT_EN to expose the occupancy register on the count port.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int unsigned  DATA_W   = DEF_DATA_W,
   parameter int unsigned  DEPTH    = DEF_DEPTH,
   parameter int unsigned  AF_LEVEL = DEPTH - 1,
   parameter int unsigned  AE_LEVEL = 1,
   localparam int unsigned CNT_W    = cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rd_en,
   output logic [DATA_W-1:0] data_out,
   output logic              wr_ack,
   output logic              overflow,
   output logic              underflow,
   output logic              full,
   output logic              empty,
   output logic              almostfull,
   output logic              almostempty
`ifdef FIFO_COUNT_EN
  ,output logic [CNT_W-1:0]  count
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_ack_q, wr_ack_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             wr_go, rd_go;
   fifo_status_t     status;

   // Wrap by compare so non-power-of-2 depths work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      status.full        = (cnt_q == CNT_W'(DEPTH));
      status.empty       = (cnt_q == '0);
      status.almostfull  = (cnt_q >= CNT_W'(AF_LEVEL)) && !status.full;
      status.almostempty = (cnt_q <= CNT_W'(AE_LEVEL)) && !status.empty;
   end

   always_comb begin
      wr_go       = wr_en && !status.full  && !flush;
      rd_go       = rd_en && !status.empty && !flush;
      wr_ack_d    = wr_go;
      overflow_d  = wr_en && status.full  && !flush;
      underflow_d = rd_en && status.empty && !flush;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (wr_go) wr_ptr_d = next_ptr(wr_ptr_q);
         if (rd_go) rd_ptr_d = next_ptr(rd_ptr_q);
         if (wr_go && !rd_go)      cnt_d = cnt_q + 1'b1;
         else if (rd_go && !wr_go) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         wr_ack_q    <= wr_ack_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_go),
      .wr_addr (wr_ptr_q),
      .wr_data (data_in),
      .rd_en   (rd_go),
      .rd_addr (rd_ptr_q),
      .rd_data (data_out)
   );

   assign wr_ack      = wr_ack_q;
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;
   assign full        = status.full;
   assign empty       = status.empty;
   assign almostfull  = status.almostfull;
   assign almostempty = status.almostempty;
`ifdef FIFO_COUNT_EN
   assign count       = cnt_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: an 8-deep default instance and a 5-deep instance.
module tb_sync_fifo_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 8-deep instance
   logic        rst = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
   logic [15:0] data_in = '0, data_out;
   logic        wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
`ifdef FIFO_COUNT_EN
   logic [3:0]  count;
`endif

   // 5-deep instance
   logic        rst5 = 1'b0, flush5 = 1'b0, wr5 = 1'b0, rd5 = 1'b0;
   logic [15:0] din5 = '0, dout5;
   logic        ack5, ovf5, udf5, full5, empty5, af5, ae5;
`ifdef FIFO_COUNT_EN
   logic [2:0]  count5;
`endif

   sync_fifo_param #(.DATA_W(16), .DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
      .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty)
`ifdef FIFO_COUNT_EN
     ,.count(count)
`endif
   );

   sync_fifo_param #(.DATA_W(16), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(1)) dut5 (
      .clk(clk), .rst(rst5), .flush(flush5), .wr_en(wr5), .data_in(din5), .rd_en(rd5),
      .data_out(dout5), .wr_ack(ack5), .overflow(ovf5), .underflow(udf5),
      .full(full5), .empty(empty5), .almostfull(af5), .almostempty(ae5)
`ifdef FIFO_COUNT_EN
     ,.count(count5)
`endif
   );

   int total = 0;
   int bad   = 0;

   // Reference model state for each instance
   logic [15:0] q8[$], q5[$];
   int          m8 = 0, m5 = 0;
   logic [15:0] e_dout8 = '0, e_dout5 = '0;
   logic        e_ack8 = 0, e_ovf8 = 0, e_udf8 = 0;
   logic        e_ack5 = 0, e_ovf5 = 0, e_udf5 = 0;

   logic [6:0] obs8, obs5;
   assign obs8 = {wr_ack, overflow, underflow, full, empty, almostfull, almostempty};
   assign obs5 = {ack5, ovf5, udf5, full5, empty5, af5, ae5};

   function automatic logic [6:0] exp8();
      return {e_ack8, e_ovf8, e_udf8, m8 == 8, m8 == 0, m8 >= 7 && m8 != 8, m8 <= 1 && m8 != 0};
   endfunction

   function automatic logic [6:0] exp5();
      return {e_ack5, e_ovf5, e_udf5, m5 == 5, m5 == 0, m5 >= 3 && m5 != 5, m5 <= 1 && m5 != 0};
   endfunction

   // One clock on the 8-deep instance; the model decides from pre-edge occupancy.
   task automatic cyc8(input logic r, input logic f, input logic w, input logic rd, input logic [15:0] d);
      logic wa, ra;
      rst = r; flush = f; wr_en = w; rd_en = rd; data_in = d;
      @(posedge clk); #1;
      wa = w && (m8 != 8);
      ra = rd && (m8 != 0);
      if (r || f) begin
         q8.delete(); m8 = 0; e_ack8 = 0; e_ovf8 = 0; e_udf8 = 0;
         if (r) e_dout8 = '0;
      end else begin
         e_ack8 = wa; e_ovf8 = w && !wa; e_udf8 = rd && !ra;
         if (wa) q8.push_back(d);
         if (ra) e_dout8 = q8.pop_front();
         m8 = m8 + int'(wa) - int'(ra);
      end
      rst = 0; flush = 0; wr_en = 0; rd_en = 0;
   endtask

   task automatic cyc5(input logic r, input logic w, input logic rd, input logic [15:0] d);
      logic wa, ra;
      rst5 = r; wr5 = w; rd5 = rd; din5 = d;
      @(posedge clk); #1;
      wa = w && (m5 != 5);
      ra = rd && (m5 != 0);
      if (r) begin
         q5.delete(); m5 = 0; e_ack5 = 0; e_ovf5 = 0; e_udf5 = 0; e_dout5 = '0;
      end else begin
         e_ack5 = wa; e_ovf5 = w && !wa; e_udf5 = rd && !ra;
         if (wa) q5.push_back(d);
         if (ra) e_dout5 = q5.pop_front();
         m5 = m5 + int'(wa) - int'(ra);
      end
      rst5 = 0; wr5 = 0; rd5 = 0;
   endtask

   task automatic test_reset();
      cyc8(1, 0, 0, 0, 16'h0);
      total++; if (obs8 !== 7'b0000100) begin bad++; $display("FAIL reset flags got=%b want=%b", obs8, 7'b0000100); end
      total++; if (data_out !== 16'h0) begin bad++; $display("FAIL reset data got=%h want=%h", data_out, 16'h0); end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 9; i++) begin
         cyc8(0, 0, 1, 0, (i == 9) ? 16'hBEEF : 16'(i));
         total++; if (obs8 !== exp8()) begin bad++; $display("FAIL fill[%0d] flags got=%b want=%b", i, obs8, exp8()); end
      end
   endtask

   task automatic test_drain();
      for (int i = 1; i <= 9; i++) begin
         cyc8(0, 0, 0, 1, 16'h0);
         total++; if (obs8 !== exp8()) begin bad++; $display("FAIL drain[%0d] flags got=%b want=%b", i, obs8, exp8()); end
         total++; if (data_out !== e_dout8) begin bad++; $display("FAIL drain[%0d] data got=%h want=%h", i, data_out, e_dout8); end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) cyc8(0, 0, 1, 0, 16'h0010 + 16'(i));
      for (int i = 0; i < 10; i++) begin
         cyc8(0, 0, 1, 1, 16'h0020 + 16'(i));
         total++; if (obs8 !== exp8()) begin bad++; $display("FAIL b2b[%0d] flags got=%b want=%b", i, obs8, exp8()); end
         total++; if (data_out !== e_dout8) begin bad++; $display("FAIL b2b[%0d] data got=%h want=%h", i, data_out, e_dout8); end
      end
   endtask

   task automatic test_full_empty_rdwr();
      for (int i = 0; i < 4; i++) cyc8(0, 0, 1, 0, 16'h0040 + 16'(i));
      total++; if (full !== 1'b1) begin bad++; $display("FAIL prefull got=%b want=1", full); end
      cyc8(0, 0, 1, 1, 16'hA5A5);
      total++; if (obs8 !== exp8()) begin bad++; $display("FAIL full_rdwr flags got=%b want=%b", obs8, exp8()); end
      total++; if (data_out !== e_dout8) begin bad++; $display("FAIL full_rdwr data got=%h want=%h", data_out, e_dout8); end
      while (m8 > 0) begin
         cyc8(0, 0, 0, 1, 16'h0);
         total++; if (data_out !== e_dout8) begin bad++; $display("FAIL full_drain data got=%h want=%h", data_out, e_dout8); end
      end
      cyc8(0, 0, 1, 1, 16'h5A5A);
      total++; if (obs8 !== exp8()) begin bad++; $display("FAIL empty_rdwr flags got=%b want=%b", obs8, exp8()); end
      total++; if (data_out !== e_dout8) begin bad++; $display("FAIL empty_rdwr data got=%h want=%h", data_out, e_dout8); end
      cyc8(0, 0, 0, 1, 16'h0);
      total++; if (data_out !== 16'h5A5A) begin bad++; $display("FAIL empty_rdwr readback got=%h want=%h", data_out, 16'h5A5A); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) cyc8(0, 0, 1, 0, 16'h0070 + 16'(i));
      cyc8(0, 1, 1, 0, 16'h7777);
      total++; if (obs8 !== 7'b0000100) begin bad++; $display("FAIL flush flags got=%b want=%b", obs8, 7'b0000100); end
      total++; if (data_out !== e_dout8) begin bad++; $display("FAIL flush data got=%h want=%h", data_out, e_dout8); end
`ifdef FIFO_COUNT_EN
      total++; if (count !== 4'd0) begin bad++; $display("FAIL flush count got=%0d want=0", count); end
`endif
      cyc8(0, 0, 0, 1, 16'h0);
      total++; if (obs8 !== exp8()) begin bad++; $display("FAIL post_flush flags got=%b want=%b", obs8, exp8()); end
   endtask

   task automatic test_reset_mid_burst();
      for (int i = 0; i < 3; i++) cyc8(0, 0, 1, 0, 16'h0090 + 16'(i));
      cyc8(0, 0, 1, 1, 16'h0099);
      cyc8(1, 0, 1, 1, 16'h00AA);
      total++; if (obs8 !== 7'b0000100) begin bad++; $display("FAIL midrst flags got=%b want=%b", obs8, 7'b0000100); end
      total++; if (data_out !== 16'h0) begin bad++; $display("FAIL midrst data got=%h want=%h", data_out, 16'h0); end
      cyc8(0, 0, 1, 0, 16'h00BB);
      cyc8(0, 0, 0, 1, 16'h0);
      total++; if (data_out !== e_dout8) begin bad++; $display("FAIL midrst readback got=%h want=%h", data_out, e_dout8); end
   endtask

   task automatic test_depth5();
      cyc5(1, 0, 0, 16'h0);
      total++; if (obs5 !== 7'b0000100) begin bad++; $display("FAIL d5 reset flags got=%b want=%b", obs5, 7'b0000100); end
      for (int i = 0; i < 6; i++) begin
         cyc5(0, 1, 0, 16'h0100 + 16'(i));
         total++; if (obs5 !== exp5()) begin bad++; $display("FAIL d5 fill[%0d] flags got=%b want=%b", i, obs5, exp5()); end
      end
      for (int i = 0; i < 2; i++) cyc5(0, 0, 1, 16'h0);
      for (int i = 0; i < 12; i++) begin
         cyc5(0, 1, 1, 16'h0200 + 16'(i));
         total++; if (obs5 !== exp5()) begin bad++; $display("FAIL d5 pair[%0d] flags got=%b want=%b", i, obs5, exp5()); end
         total++; if (dout5 !== e_dout5) begin bad++; $display("FAIL d5 pair[%0d] data got=%h want=%h", i, dout5, e_dout5); end
      end
      for (int i = 0; i < 4; i++) begin
         cyc5(0, 0, 1, 16'h0);
         total++; if (obs5 !== exp5()) begin bad++; $display("FAIL d5 drain[%0d] flags got=%b want=%b", i, obs5, exp5()); end
         total++; if (dout5 !== e_dout5) begin bad++; $display("FAIL d5 drain[%0d] data got=%h want=%h", i, dout5, e_dout5); end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_back_to_back();
      test_full_empty_rdwr();
      test_flush();
      test_reset_mid_burst();
      test_depth5();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
